// File: rtl/bary_pkg.sv
// ----------------------------------------------------------------------------
// bary_pkg
// Shared definitions for the barycentric-to-Cartesian converter:
//   INT_BITS   default integer bits of vertex coordinates
//   DEC_BITS   default fraction bits of barycentric weights
//   FIXED_ONE  fixed-point encoding of 1.0 for the weights
//   STEP_COUNT number of multiply-accumulate steps per result
//   state_e    converter FSM state encoding
// ----------------------------------------------------------------------------
package bary_pkg;

    localparam int INT_BITS   = 4;
    localparam int DEC_BITS   = 8;
    localparam int FIXED_ONE  = 1 << DEC_BITS;
    localparam int STEP_COUNT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : bary_pkg

// File: rtl/fx_mult.sv
// ----------------------------------------------------------------------------
// fx_mult
// Combinational signed multiplier: fixed-point weight times integer coordinate.
// The product is full width, so no bits are lost.
// Ports:
//   w_i  signed weight, WW bits
//   c_i  signed coordinate, CW bits
//   p_o  signed product, WW+CW bits
// ----------------------------------------------------------------------------
module fx_mult #(
    parameter int WW = 13,
    parameter int CW = 5
) (
    input  logic signed [WW-1:0]    w_i,
    input  logic signed [CW-1:0]    c_i,
    output logic signed [WW+CW-1:0] p_o
);

    logic signed [WW+CW-1:0] w_ext;
    logic signed [WW+CW-1:0] c_ext;

    assign w_ext = {{CW{w_i[WW-1]}}, w_i};
    assign c_ext = {{WW{c_i[CW-1]}}, c_i};
    assign p_o   = w_ext * c_ext;

endmodule : fx_mult

// File: rtl/bary_to_cartesian.sv
// ----------------------------------------------------------------------------
// bary_to_cartesian
// Converts barycentric weights plus three triangle vertices into a Cartesian
// point: x = l0*x0 + l1*x1 + l2*x2, y likewise. A single shared multiplier
// processes one product per cycle in the order x0,x1,x2,y0,y1,y2; the result
// is saturated to the fixed-point output width and to the integer pixel width.
//
// Ports:
//   clk                     sole clock, rising edge
//   rst_n                   asynchronous active-low reset
//   x_0..y_2                signed vertex coordinates (intBits+1)
//   lambda_0..lambda_2      signed fixed-point weights (intBits+decimalBits+1)
//   in_valid / in_ready     operand handshake (ready only while idle)
//   x_fx, y_fx              saturated fixed-point result
//   x_pix, y_pix            saturated integer result
//   out_valid / out_ready   result handshake
//   ovf                     any of the four result components saturated
//
// Build option:
//   BARY_ROUND_EN  defined: x_pix/y_pix round half up before saturation;
//                  undefined: x_pix/y_pix truncate toward minus infinity.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | in_ready high; outputs hold last result; accept loads operands
// CALC  | steps 0..5 accumulate one product each; step 6 saturates/registers
// DONE  | out_valid high, outputs stable until out_ready is sampled high
// ----------------------------------------------------------------------------
module bary_to_cartesian
    import bary_pkg::*;
#(
    parameter int intBits     = INT_BITS,
    parameter int decimalBits = DEC_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic signed [intBits:0]               x_0,
    input  logic signed [intBits:0]               y_0,
    input  logic signed [intBits:0]               x_1,
    input  logic signed [intBits:0]               y_1,
    input  logic signed [intBits:0]               x_2,
    input  logic signed [intBits:0]               y_2,
    input  logic signed [intBits+decimalBits:0]   lambda_0,
    input  logic signed [intBits+decimalBits:0]   lambda_1,
    input  logic signed [intBits+decimalBits:0]   lambda_2,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic signed [intBits+decimalBits:0]   x_fx,
    output logic signed [intBits+decimalBits:0]   y_fx,
    output logic signed [intBits:0]               x_pix,
    output logic signed [intBits:0]               y_pix,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  ovf
);

    localparam int CW = intBits + 1;
    localparam int WW = intBits + decimalBits + 1;
    localparam int PW = WW + CW;
    localparam int AW = PW + 2;

    localparam logic signed [AW-1:0] FX_MAX  = AW'((1 << (WW - 1)) - 1);
    localparam logic signed [AW-1:0] FX_MIN  = ~FX_MAX;
    localparam logic signed [AW:0]   PIX_MAX = (AW+1)'((1 << (CW - 1)) - 1);
    localparam logic signed [AW:0]   PIX_MIN = ~PIX_MAX;
`ifdef BARY_ROUND_EN
    localparam logic signed [AW:0]   PIX_RND = (AW+1)'(1 << (decimalBits - 1));
`else
    localparam logic signed [AW:0]   PIX_RND = '0;
`endif

    // {saturated flag, value}
    function automatic logic [WW:0] sat_fx(input logic signed [AW-1:0] a);
        if (a > FX_MAX) begin
            return {1'b1, FX_MAX[WW-1:0]};
        end else if (a < FX_MIN) begin
            return {1'b1, FX_MIN[WW-1:0]};
        end
        return {1'b0, a[WW-1:0]};
    endfunction

    // One extra bit keeps the rounding add from wrapping before the shift.
    function automatic logic [CW:0] sat_pix(input logic signed [AW-1:0] a);
        logic signed [AW:0] r;
        r = $signed({a[AW-1], a}) + PIX_RND;
        r = r >>> decimalBits;
        if (r > PIX_MAX) begin
            return {1'b1, PIX_MAX[CW-1:0]};
        end else if (r < PIX_MIN) begin
            return {1'b1, PIX_MIN[CW-1:0]};
        end
        return {1'b0, r[CW-1:0]};
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              step_q,  step_d;
    logic signed [WW-1:0]    lam_q [3];
    logic signed [WW-1:0]    lam_d [3];
    logic signed [CW-1:0]    xc_q  [3];
    logic signed [CW-1:0]    xc_d  [3];
    logic signed [CW-1:0]    yc_q  [3];
    logic signed [CW-1:0]    yc_d  [3];
    logic signed [AW-1:0]    acc_x_q, acc_x_d;
    logic signed [AW-1:0]    acc_y_q, acc_y_d;
    logic signed [WW-1:0]    x_fx_q,  x_fx_d;
    logic signed [WW-1:0]    y_fx_q,  y_fx_d;
    logic signed [CW-1:0]    x_pix_q, x_pix_d;
    logic signed [CW-1:0]    y_pix_q, y_pix_d;
    logic                    ovf_q,   ovf_d;

    logic signed [WW-1:0]    mul_w;
    logic signed [CW-1:0]    mul_c;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;
    logic [WW:0]             sx_fx, sy_fx;
    logic [CW:0]             sx_pix, sy_pix;

    // Operand select for the shared multiplier: steps 0..2 feed x, 3..5 feed y.
    always_comb begin
        mul_w = lam_q[0];
        mul_c = xc_q[0];
        case (step_q)
            3'd0: begin mul_w = lam_q[0]; mul_c = xc_q[0]; end
            3'd1: begin mul_w = lam_q[1]; mul_c = xc_q[1]; end
            3'd2: begin mul_w = lam_q[2]; mul_c = xc_q[2]; end
            3'd3: begin mul_w = lam_q[0]; mul_c = yc_q[0]; end
            3'd4: begin mul_w = lam_q[1]; mul_c = yc_q[1]; end
            3'd5: begin mul_w = lam_q[2]; mul_c = yc_q[2]; end
            default: begin mul_w = lam_q[0]; mul_c = xc_q[0]; end
        endcase
    end

    fx_mult #(
        .WW (WW),
        .CW (CW)
    ) u_fx_mult (
        .w_i (mul_w),
        .c_i (mul_c),
        .p_o (prod)
    );

    assign prod_ext = {{2{prod[PW-1]}}, prod};

    assign sx_fx  = sat_fx(acc_x_q);
    assign sy_fx  = sat_fx(acc_y_q);
    assign sx_pix = sat_pix(acc_x_q);
    assign sy_pix = sat_pix(acc_y_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lam_d   = lam_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        x_fx_d  = x_fx_q;
        y_fx_d  = y_fx_q;
        x_pix_d = x_pix_q;
        y_pix_d = y_pix_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    step_d   = 3'd0;
                    lam_d[0] = lambda_0;
                    lam_d[1] = lambda_1;
                    lam_d[2] = lambda_2;
                    xc_d[0]  = x_0;
                    xc_d[1]  = x_1;
                    xc_d[2]  = x_2;
                    yc_d[0]  = y_0;
                    yc_d[1]  = y_1;
                    yc_d[2]  = y_2;
                    acc_x_d  = '0;
                    acc_y_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            CALC: begin
                if (step_q == 3'(STEP_COUNT)) begin
                    // Accumulation finished last cycle; register saturated result.
                    state_d = DONE;
                    step_d  = 3'd0;
                    x_fx_d  = sx_fx[WW-1:0];
                    y_fx_d  = sy_fx[WW-1:0];
                    x_pix_d = sx_pix[CW-1:0];
                    y_pix_d = sy_pix[CW-1:0];
                    ovf_d   = sx_fx[WW] | sy_fx[WW] | sx_pix[CW] | sy_pix[CW];
                end else begin
                    step_d = step_q + 3'd1;
                    if (step_q < 3'd3) begin
                        acc_x_d = acc_x_q + prod_ext;
                    end else begin
                        acc_y_d = acc_y_q + prod_ext;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                lam_q[i] <= '0;
                xc_q[i]  <= '0;
                yc_q[i]  <= '0;
            end
            acc_x_q <= '0;
            acc_y_q <= '0;
            x_fx_q  <= '0;
            y_fx_q  <= '0;
            x_pix_q <= '0;
            y_pix_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lam_q   <= lam_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            x_fx_q  <= x_fx_d;
            y_fx_q  <= y_fx_d;
            x_pix_q <= x_pix_d;
            y_pix_q <= y_pix_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x_fx      = x_fx_q;
    assign y_fx      = y_fx_q;
    assign x_pix     = x_pix_q;
    assign y_pix     = y_pix_q;
    assign ovf       = ovf_q;

endmodule : bary_to_cartesian

// File: tb/tb_bary_to_cartesian.sv
module tb_bary_to_cartesian;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [4:0]  x_0, y_0, x_1, y_1, x_2, y_2;
    logic signed [12:0] lambda_0, lambda_1, lambda_2;
    logic               in_valid;
    logic               in_ready;
    logic signed [12:0] x_fx, y_fx;
    logic signed [4:0]  x_pix, y_pix;
    logic               out_valid;
    logic               out_ready;
    logic               ovf;

    always #5 clk = ~clk;

    bary_to_cartesian dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_0       (x_0),
        .y_0       (y_0),
        .x_1       (x_1),
        .y_1       (y_1),
        .x_2       (x_2),
        .y_2       (y_2),
        .lambda_0  (lambda_0),
        .lambda_1  (lambda_1),
        .lambda_2  (lambda_2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_fx      (x_fx),
        .y_fx      (y_fx),
        .x_pix     (x_pix),
        .y_pix     (y_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

`ifdef BARY_ROUND_EN
    localparam int RND      = 128;
    localparam int EXP_HALF = 3;
`else
    localparam int RND      = 0;
    localparam int EXP_HALF = 2;
`endif

    typedef struct {
        int x_fx;
        int y_fx;
        int x_pix;
        int y_pix;
        int ovf;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic res_t model(input int x0, input int y0, input int x1, input int y1,
                                   input int x2, input int y2,
                                   input int l0, input int l1, input int l2);
        res_t r;
        int ax, ay, px, py;
        ax = l0 * x0 + l1 * x1 + l2 * x2;
        ay = l0 * y0 + l1 * y1 + l2 * y2;
        px = (ax + RND) >>> 8;
        py = (ay + RND) >>> 8;
        r.x_fx  = clamp(ax, -4096, 4095);
        r.y_fx  = clamp(ay, -4096, 4095);
        r.x_pix = clamp(px, -16, 15);
        r.y_pix = clamp(py, -16, 15);
        r.ovf   = ((r.x_fx != ax) || (r.y_fx != ay) || (r.x_pix != px) || (r.y_pix != py)) ? 1 : 0;
        return r;
    endfunction

    task automatic drive_ops(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2,
                             input int l0, input int l1, input int l2);
        x_0 = 5'(x0); y_0 = 5'(y0);
        x_1 = 5'(x1); y_1 = 5'(y1);
        x_2 = 5'(x2); y_2 = 5'(y2);
        lambda_0 = 13'(l0); lambda_1 = 13'(l1); lambda_2 = 13'(l2);
    endtask

    task automatic scramble_ops();
        drive_ops(int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(8191)) - 4096, int'($urandom_range(8191)) - 4096,
                  int'($urandom_range(8191)) - 4096);
    endtask

    // One full transaction; hold = cycles out_ready stays low once DONE.
    task automatic do_op(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2,
                         input int l0, input int l1, input int l2,
                         input int hold, output res_t got);
        res_t exp;
        int   k;
        @(negedge clk);
        check_val("in_ready_idle", int'(in_ready), 1);
        drive_ops(x0, y0, x1, y1, x2, y2, l0, l1, l2);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb_q.push_back(model(x0, y0, x1, y1, x2, y2, l0, l1, l2));
        @(negedge clk);
        in_valid = 1'b0;
        scramble_ops();
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("latency", k, 7);
        exp = sb_q.pop_front();
        got.x_fx  = int'(x_fx);
        got.y_fx  = int'(y_fx);
        got.x_pix = int'(x_pix);
        got.y_pix = int'(y_pix);
        got.ovf   = int'(ovf);
        check_val("x_fx",  got.x_fx,  exp.x_fx);
        check_val("y_fx",  got.y_fx,  exp.y_fx);
        check_val("x_pix", got.x_pix, exp.x_pix);
        check_val("y_pix", got.y_pix, exp.y_pix);
        check_val("ovf",   got.ovf,   exp.ovf);
        for (int i = 0; i < hold; i++) begin
            check_val("hold_out_valid", int'(out_valid), 1);
            check_val("hold_in_ready",  int'(in_ready), 0);
            check_val("hold_x_fx",  int'(x_fx),  exp.x_fx);
            check_val("hold_y_pix", int'(y_pix), exp.y_pix);
            in_valid = i[0];
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_out_valid", int'(out_valid), 0);
        check_val("post_in_ready",  int'(in_ready), 1);
        check_val("idle_hold_x_fx", int'(x_fx), exp.x_fx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t g;
        int   seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_x_fx", int'(x_fx), 0);
        check_val("rst_y_fx", int'(y_fx), 0);
        check_val("rst_x_pix", int'(x_pix), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        do_op(2, 1, 10, 3, 6, 9, 'h100, 0, 0, 0, g);
        check_val("v1_x_pix", g.x_pix, 2);
        check_val("v1_y_pix", g.y_pix, 1);
        check_val("v1_x_fx", g.x_fx, 'h200);
        check_val("v1_ovf", g.ovf, 0);

        do_op(2, 1, 10, 3, 6, 9, 'h055, 'h055, 'h056, 0, g);
        check_val("v2_x_fx", g.x_fx, 'h600);
        check_val("v2_y_fx", g.y_fx, 'h45A);
        check_val("v2_x_pix", g.x_pix, 6);
        check_val("v2_y_pix", g.y_pix, 4);

        do_op(5, 0, 0, 0, 0, 0, 'h080, 'h080, 0, 0, g);
        check_val("v3_x_fx", g.x_fx, 'h280);
        check_val("v3_x_pix", g.x_pix, EXP_HALF);

        do_op(15, 15, 0, 0, 0, 0, 'h200, 0, 0, 0, g);
        check_val("v4_x_pix", g.x_pix, 15);
        check_val("v4_y_pix", g.y_pix, 15);
        check_val("v4_x_fx", g.x_fx, 4095);
        check_val("v4_y_fx", g.y_fx, 4095);
        check_val("v4_ovf", g.ovf, 1);

        do_op(2, 1, 10, 3, 6, 9, 'h055, 'h055, 'h056, 5, g);
        check_val("v5_ovf_cleared", g.ovf, 0);

        do_op(-16, 15, -3, 7, 4, -9, -'h200, 'h0C0, -'h040, 0, g);

        for (int n = 0; n < 6; n++) begin
            do_op(int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                  int'($urandom_range(8191)) - 4096, int'($urandom_range(8191)) - 4096,
                  int'($urandom_range(8191)) - 4096, n % 3, g);
        end

        // Make the held outputs nonzero so the reset clear is observable.
        do_op(2, 1, 10, 3, 6, 9, 'h055, 'h055, 'h056, 0, g);

        @(negedge clk);
        drive_ops(15, 15, 0, 0, 0, 0, 'h100, 0, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_x_fx", int'(x_fx), 0);
        check_val("abort_y_fx", int'(y_fx), 0);
        check_val("abort_x_pix", int'(x_pix), 0);
        check_val("abort_y_pix", int'(y_pix), 0);
        check_val("abort_ovf", int'(ovf), 0);
        check_val("abort_out_valid", int'(out_valid), 0);
        check_val("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_val("abort_no_valid", seen, 0);

        do_op(2, 1, 10, 3, 6, 9, 'h055, 'h055, 'h056, 0, g);
        check_val("fresh_y_fx", g.y_fx, 'h45A);

        check_val("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bary_to_cartesian
